// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the register-file arbiter.
// rr_pick is the round-robin search used by rr_arbiter.
package reg_arb_pkg;

  localparam int DataWidth      = 32;
  localparam int StrbWidth      = 4;
  localparam int ReqOffsetWidth = 6;
  localparam int MaxPorts       = 8;

  typedef struct packed {
    logic                      write;
    logic                      lock;
    logic [ReqOffsetWidth-1:0] offset;
    logic [DataWidth-1:0]      wdata;
    logic [StrbWidth-1:0]      strb;
  } req_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // Walk from farthest to nearest so the port right after ptr wins last.
  function automatic pick_t rr_pick(input logic [MaxPorts-1:0] valid,
                                    input logic [2:0]          ptr,
                                    input int                  num_ports);
    pick_t      res;
    logic [2:0] p;
    res = '0;
    for (int i = MaxPorts; i >= 1; i--) begin
      if (i <= num_ports) begin
        p = 3'((int'(ptr) + i) % num_ports);
        if (valid[p]) begin
          res.found = 1'b1;
          res.idx   = p;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_file_arbiter_rr.sv
// Round-robin grant with a pointer register and a single-owner lock.
// The lock only binds while its owner keeps requesting.
module rr_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NumPorts = 2,
  parameter int IdxWidth = $clog2(NumPorts)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NumPorts-1:0] valid,
  input  logic [NumPorts-1:0] lock,
  output logic [NumPorts-1:0] grant,
  output logic [IdxWidth-1:0] grant_idx,
  output logic                grant_found
);

  logic [IdxWidth-1:0] ptr_q;
  logic [IdxWidth-1:0] owner_q;
  logic                lock_q;
  logic                owner_holds;
  pick_t               pick;

  assign owner_holds = lock_q & valid[owner_q];

  always_comb begin
    pick        = rr_pick(MaxPorts'(valid), 3'(ptr_q), NumPorts);
    grant_found = 1'b0;
    grant_idx   = '0;
    grant       = '0;
    if (reset_n) begin
      if (owner_holds) begin
        grant_found = 1'b1;
        grant_idx   = owner_q;
      end else if (pick.found) begin
        grant_found = 1'b1;
        grant_idx   = IdxWidth'(pick.idx);
      end
    end
    if (grant_found) grant[grant_idx] = 1'b1;
  end

  // Any cycle without an accept means the owner let go, so the lock drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      owner_q <= '0;
      lock_q  <= 1'b0;
    end else if (grant_found) begin
      ptr_q   <= grant_idx;
      owner_q <= grant_idx;
      lock_q  <= lock[grant_idx];
    end else begin
      lock_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_arbiter.sv
// Shares one single-port register file between NumPorts requesters, one
// access per cycle, with a registered response to the granted port.
module reg_file_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NumPorts = 2,
  parameter int NumWords = 64,
  localparam int OffsetWidth = $clog2(NumWords)
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NumPorts-1:0]                   req_valid,
  output logic [NumPorts-1:0]                   req_ready,
  input  logic [NumPorts-1:0]                   req_write,
  input  logic [NumPorts-1:0]                   req_lock,
  input  logic [NumPorts-1:0][OffsetWidth-1:0]  req_offset,
  input  logic [NumPorts-1:0][DataWidth-1:0]    req_wdata,
  input  logic [NumPorts-1:0][StrbWidth-1:0]    req_strb,
  output logic [NumPorts-1:0]                   rsp_valid,
  output logic [DataWidth-1:0]                  rsp_rdata,
  output logic [OffsetWidth-1:0]                rf_offset,
  output logic [DataWidth-1:0]                  rf_wd,
  output logic [StrbWidth-1:0]                  rf_we,
  input  logic [DataWidth-1:0]                  rf_rd
);

  localparam int IdxWidth = $clog2(NumPorts);

  logic [IdxWidth-1:0]    grant_idx;
  logic                   grant_found;
  logic [OffsetWidth-1:0] offset_q;
  logic [DataWidth-1:0]   wd_q;

  rr_arbiter #(
    .NumPorts (NumPorts),
    .IdxWidth (IdxWidth)
  ) u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .valid       (req_valid),
    .lock        (req_lock),
    .grant       (req_ready),
    .grant_idx   (grant_idx),
    .grant_found (grant_found)
  );

  // Idle cycles keep presenting the last offset and data to the file.
  always_comb begin
    rf_offset = offset_q;
    rf_wd     = wd_q;
    rf_we     = '0;
    if (grant_found) begin
      rf_offset = req_offset[grant_idx];
      rf_wd     = req_wdata[grant_idx];
      if (req_write[grant_idx]) rf_we = req_strb[grant_idx];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      offset_q  <= '0;
      wd_q      <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= req_ready;
      if (grant_found) begin
        offset_q  <= rf_offset;
        wd_q      <= rf_wd;
        rsp_rdata <= req_write[grant_idx] ? '0 : rf_rd;
      end
    end
  end

endmodule

// File: doc/reg_file_arbiter.md
Name: reg_file_arbiter

Overview:
- Shares one single-port 32-bit register file between NumPorts requesters, e.g. the AHB slave side and a local hardware engine.
- Arbitrates at most one access per cycle using round-robin priority, with an optional lock for atomic multi-access sequences.
- Drives the register file's offset, write-data and byte-enable inputs.
- Samples the file's combinational read data and returns it as a registered response to the granted requester.

Parameters:
- NumPorts, 2, number of requesters (2..8).
- NumWords, 64, register file depth. Local constant OffsetWidth = $clog2(NumWords).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NumPorts  per-port request valid.
- req_ready  out  NumPorts  per-port accept; one-hot or zero.
- req_write  in  NumPorts  1 = write, 0 = read.
- req_lock  in  NumPorts  keep grant after this access.
- req_offset  in  NumPorts x OffsetWidth  word offset.
- req_wdata  in  NumPorts x 32  write data.
- req_strb  in  NumPorts x 4  byte strobes; ignored on reads.
- rsp_valid  out  NumPorts  per-port response pulse.
- rsp_rdata  out  32  read data, shared by all ports.
- rf_offset  out  OffsetWidth  to register file.
- rf_wd  out  32  to register file.
- rf_we  out  4  to register file byte enables.
- rf_rd  in  32  from register file; combinational read of rf_offset.

Behaviour:
- Reset values: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rf_we = 0, rf_offset = 0, rf_wd = 0. Priority pointer = 0, lock owner = none.
- Registered state: priority pointer (last granted port), lock_active flag plus lock_owner index, rsp_valid register, rsp_rdata register.
- Grant (combinational, same cycle):
  - If lock_active, only lock_owner may be granted.
  - Otherwise grant the first requesting port at or after (pointer+1) mod NumPorts.
  - req_ready[g] = 1 only for the granted port g with req_valid[g] = 1. No grant means req_ready = 0 and rf_we = 0.
- Datapath mux (combinational):
  - rf_offset = req_offset[g]; rf_wd = req_wdata[g].
  - rf_we = req_strb[g] if req_write[g] is set and granted, else 0.
  - With no grant, rf_offset holds the previous value; rf_we = 0.
- Accept = req_valid & req_ready. On the edge after an accept:
  - pointer <= g.
  - rsp_valid[g] <= 1 for exactly one cycle.
  - Read: rsp_rdata <= rf_rd as seen in the accept cycle.
  - Write: rsp_rdata <= 0.
- Latency: request-to-response is 1 cycle. A port may issue back-to-back accepts only when it is the sole requester or holds the lock.
- Lock:
  - An accept with req_lock[g] = 1 sets lock_active = 1 and lock_owner = g.
  - An accept by the owner with req_lock = 0 clears the lock after that access.
  - If the owner deasserts req_valid while locked, the lock clears that cycle and other ports may be granted in the same cycle.
  - Other ports stall with req_ready = 0 while the lock is held.
- Write then read of the same offset in consecutive cycles: the read returns the new data, because the file write lands on the edge. There are no same-cycle hazards, since there is one access per cycle.
- A port must hold its request fields stable while req_valid = 1 and req_ready = 0. The bench asserts this.
- Responses have no backpressure; requesters must accept rsp_valid.
- Mid-operation reset: all state returns to reset values immediately; in-flight responses are discarded.
- Out-of-range offset (offset >= NumWords when NumWords is not a power of 2): passed through unchanged; behaviour is defined by the file.

Decomposition:
- Package reg_arb_pkg holds:
  - localparam DataWidth = 32 and StrbWidth = 4;
  - typedef req_t (write, lock, offset, wdata, strb), with offset width set by a package parameter default of 6;
  - function rr_pick(valid vector, pointer) returning the grant index and found flag.
- One sub-module, rr_arbiter: NumPorts-wide round-robin grant with pointer register and lock logic, outputting a one-hot grant and an index.
- The datapath mux and response registers stay in reg_file_arbiter.

Test Plan:
- Reset, then port0 writes offset 5, data 0xDEADBEEF, strb 0xF; next cycle port0 reads offset 5 -> rsp_valid[0] pulses one cycle after each accept, and the read response has rsp_rdata = 0xDEADBEEF.
- Both ports request continuously (reads) starting from pointer 0 -> grants alternate 1,0,1,0; each port gets exactly 50 of 100 cycles.
- Port0 sets req_lock for 3 accesses (last with lock = 0) while port1 is requesting -> port1 req_ready = 0 for those 3 cycles, then port1 is granted the next cycle.
- Partial write with strb 0b0101, data 0x11223344, onto a word holding 0xAAAAAAAA -> subsequent read returns 0xAA22AA44.
- Lock owner drops req_valid mid-lock -> the lock clears and port1 is granted in that same cycle.
- Assert reset_n low during a read accept cycle -> rsp_valid stays 0, rf_we = 0, and after release the pointer starts at 0 (port1 wins first if both request).
